// File: rtl/light_pwm_ramp_driver_if.sv
// light_pwm_ramp_driver_if: lamp level and enable in, PWM drive and ramp status out
interface light_pwm_ramp_driver_if #(parameter int PWM_BITS = 8);
    logic [2:0] I;
    logic en;
    logic pwm_out;
    logic [PWM_BITS-1:0] duty;
    logic ramping;
    logic at_target;
    modport master(output I, en, input pwm_out, duty, ramping, at_target);
    modport slave(input I, en, output pwm_out, duty, ramping, at_target);
endinterface

// File: rtl/light_pwm_ramp_driver.sv
// light_pwm_ramp_driver: maps lamp level to a PWM duty and ramps the applied duty toward it at period boundaries
module light_pwm_ramp_driver #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_PERIODS = 2,
    parameter int STEP = 16
) (
    input logic clk,
    input logic rst,
    light_pwm_ramp_driver_if.slave bus
);
    localparam int MAX = 2**PWM_BITS - 1;
    localparam int PW = $clog2(RAMP_PERIODS + 1);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t state, ns;
    logic [PWM_BITS-1:0] cnt, target;
    logic [PW-1:0] per_cnt;
    logic [2:0] i_q;
    logic boundary, step_pt;
    logic [PWM_BITS:0] t9, d9, diff_up, diff_dn, mu, md, n9, stp;
    always_comb begin
        boundary = cnt == PWM_BITS'(MAX);
        step_pt = boundary && per_cnt == PW'(RAMP_PERIODS - 1);
        target = !bus.en ? '0 : i_q == 3'd7 ? PWM_BITS'(MAX) : {i_q, {(PWM_BITS-3){1'b0}}};
        stp = (PWM_BITS+1)'(STEP);
        t9 = {1'b0, target};
        d9 = {1'b0, bus.duty};
        diff_up = t9 - d9;
        diff_dn = d9 - t9;
        mu = diff_up > stp ? stp : diff_up;
        md = diff_dn > stp ? stp : diff_dn;
        // disable drops the duty straight to zero; otherwise step only at step points
        n9 = !bus.en ? '0 : !step_pt ? d9 : t9 > d9 ? d9 + mu : d9 - md;
        ns = n9 == t9 ? IDLE : n9 < t9 ? UP : DOWN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            per_cnt <= '0;
            i_q <= '0;
            bus.duty <= '0;
            bus.pwm_out <= 1'b0;
            state <= IDLE;
            bus.ramping <= 1'b0;
            bus.at_target <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (boundary) per_cnt <= step_pt ? '0 : per_cnt + 1'b1;
            i_q <= bus.I;
            bus.pwm_out <= bus.en && cnt < bus.duty;
            bus.duty <= n9[PWM_BITS-1:0];
            state <= ns;
            bus.ramping <= ns != IDLE;
            bus.at_target <= ns == IDLE;
        end
    end
endmodule

// File: tb/tb_light_pwm_ramp_driver.sv
// tb_light_pwm_ramp_driver: directed vectors for level mapping, ramp stepping, enable and reset corners
module tb_light_pwm_ramp_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    light_pwm_ramp_driver_if #(.PWM_BITS(8)) d();
    light_pwm_ramp_driver #(.PWM_BITS(8), .RAMP_PERIODS(2), .STEP(16)) dut (.clk(clk), .rst(rst), .bus(d));
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] i;
        int tgt;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) begin
            tick();
            chk("rst_pwm", d.pwm_out, 0);
            chk("rst_duty", d.duty, 0);
            chk("rst_at_target", d.at_target, 1);
            chk("rst_ramping", d.ramping, 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // right after release: ramping within 2 edges, first step lands exactly on edge 512
    task automatic release_check();
        tick();
        tick();
        chk("ramping_after_rst", d.ramping, 1);
        repeat (509) tick();
        chk("pre_first_step", d.duty, 0);
        tick();
        chk("first_step", d.duty, 16);
    endtask

    task automatic settle(input int tgt);
        int n = 0;
        int last = -1;
        int prev = int'(d.duty);
        int high = 0;
        int want;
        bit done = 0;
        while (!done && n < 12000) begin
            tick();
            n++;
            if (int'(d.duty) != prev) begin
                want = tgt > prev ? prev + ((tgt - prev) > 16 ? 16 : tgt - prev)
                                  : prev - ((prev - tgt) > 16 ? 16 : prev - tgt);
                chk("step_value", d.duty, want);
                if (last >= 0) chk("step_spacing", n - last, 512);
                last = n;
                prev = int'(d.duty);
            end
            done = n >= 3 && d.at_target === 1'b1 && int'(d.duty) == tgt;
        end
        chk("settled_duty", d.duty, tgt);
        chk("settled_at_target", d.at_target, 1);
        chk("settled_ramping", d.ramping, 0);
        repeat (256) begin
            tick();
            high += int'(d.pwm_out);
        end
        chk("pwm_high_count", high, tgt);
    endtask

    task automatic wait_duty(input int v);
        int n = 0;
        while (int'(d.duty) != v && n < 6000) begin
            tick();
            n++;
        end
        chk("wait_duty", d.duty, v);
    endtask

    initial begin
        tbl[0] = '{3'd7, 255};
        tbl[1] = '{3'd0, 0};
        tbl[2] = '{3'd3, 96};
        tbl[3] = '{3'd6, 192};
        tbl[4] = '{3'd1, 32};
        tbl[5] = '{3'd5, 160};
        tbl[6] = '{3'd2, 64};
        d.I = 3'd5;
        d.en = 1'b1;
        rst_pulse(3);
        release_check();
        d.I = 3'd4;
        rst_pulse(1);
        release_check();
        settle(128);
        for (int k = 0; k < 7; k++) begin
            d.I = tbl[k].i;
            settle(tbl[k].tgt);
        end
        d.I = 3'd6;
        wait_duty(96);
        d.I = 3'd1;
        repeat (3) tick();
        chk("flip_ramping", d.ramping, 1);
        settle(32);
        d.I = 3'd4;
        settle(128);
        d.en = 1'b0;
        tick();
        chk("en_off_pwm", d.pwm_out, 0);
        chk("en_off_duty", d.duty, 0);
        chk("en_off_at_target", d.at_target, 1);
        repeat (300) tick();
        chk("en_off_hold", d.duty, 0);
        d.en = 1'b1;
        settle(128);
        d.I = 3'd6;
        wait_duty(160);
        repeat (100) tick();
        rst_pulse(1);
        release_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
